relu_stream_scheduler: RTL and testbench

//   Sequences a DATACHANNEL x DATAHEIGHT x DATAWIDTH feature map through a shared

---
 rtl/relu_stream_scheduler.sv | 120 ++++++++++++
 tb/tb_relu_stream_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_stream_scheduler.sv
// Streams a feature map through a shared bank of LANES ReLU units, one word per cycle,
// with read/write address generation and a 2-entry credit-controlled output FIFO.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing source reads
// DRAIN | all reads issued, flushing remaining writes
// DONE  | single-cycle completion pulse
module relu_stream_scheduler #(
    parameter int BITWIDTH    = 16,
    parameter int DATAWIDTH   = 7,
    parameter int DATAHEIGHT  = 7,
    parameter int DATACHANNEL = 4,
    parameter int LANES       = 7,
    parameter int ADDR_W      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic [LANES*BITWIDTH-1:0] rd_data,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [LANES*BITWIDTH-1:0] wr_data,
    input  logic                      wr_ready,
    output logic                      busy,
    output logic                      done
);

    localparam int ELEMS = DATACHANNEL * DATAHEIGHT * DATAWIDTH;
    localparam int WORDS = (ELEMS + LANES - 1) / LANES;
    localparam int DW    = LANES * BITWIDTH;
    localparam logic [ADDR_W-1:0] WORDS_A = ADDR_W'(WORDS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic              inflight_q;
    logic [1:0]        fifo_cnt_q, fifo_cnt_d;
    logic              wr_ptr_q, rd_ptr_q;
    logic [DW-1:0]     fifo_mem_q [2];
    logic [DW-1:0]     relu_word;
    logic              accept, push, pop;
    logic [2:0]        occ;

    assign accept  = (state_q == S_IDLE) && start;
    assign push    = inflight_q;
    assign pop     = wr_en && wr_ready;
    assign wr_en   = (fifo_cnt_q != 2'd0);
    assign wr_data = fifo_mem_q[rd_ptr_q];
    assign wr_addr = wr_cnt_q;
    assign rd_addr = rd_cnt_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);

    // Occupancy the FIFO will hold once the current push/pop settle; a new read is only
    // issued if its data is guaranteed a free slot when it lands next cycle.
    assign occ   = {1'b0, fifo_cnt_q} + {2'b0, push} - {2'b0, pop};
    assign rd_en = (state_q == S_RUN) && (rd_cnt_q < WORDS_A) && (occ < 3'd2);

    always_comb begin
        relu_word = '0;
        for (int i = 0; i < LANES; i++) begin
            relu_word[i*BITWIDTH +: BITWIDTH] =
                rd_data[i*BITWIDTH + BITWIDTH - 1] ? '0 : rd_data[i*BITWIDTH +: BITWIDTH];
        end
    end

    always_comb begin
        rd_cnt_d   = accept ? '0 : rd_cnt_q + ADDR_W'(rd_en);
        wr_cnt_d   = accept ? '0 : wr_cnt_q + ADDR_W'(pop);
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (rd_cnt_q == WORDS_A) state_d = S_DRAIN;
            // Look at the post-write count so DONE follows the final write directly.
            S_DRAIN: if (wr_cnt_d == WORDS_A) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rd_cnt_q      <= '0;
            wr_cnt_q      <= '0;
            inflight_q    <= 1'b0;
            fifo_cnt_q    <= 2'd0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            inflight_q <= rd_en;
            fifo_cnt_q <= fifo_cnt_d;
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= relu_word;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_relu_stream_scheduler.sv
// Directed bench for relu_stream_scheduler: latency, ReLU lanes, backpressure,
// random ready, start-while-busy and mid-pass reset.
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) passes++; else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); end

module tb_relu_stream_scheduler;
    localparam int BW    = 16;
    localparam int LANES = 7;
    localparam int AW    = 8;
    localparam int WORDS = 28;
    localparam int DW    = LANES * BW;

    logic          clk = 1'b0;
    logic          rst_n, start, wr_ready;
    logic [DW-1:0] rd_data = '0;
    logic          rd_en, wr_en, busy, done;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data;

    relu_stream_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] src [WORDS];
    int checks = 0, passes = 0;

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++)
            r[i*BW +: BW] = w[i*BW + BW - 1] ? 16'h0000 : w[i*BW +: BW];
        return r;
    endfunction

    // Source buffer: data valid the cycle after rd_en.
    logic          pend = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    always @(negedge clk) begin
        pend      = rd_en;
        pend_addr = rd_addr;
    end
    always @(posedge clk) begin
        #1;
        if (pend && pend_addr < AW'(WORDS)) rd_data = src[pend_addr];
        else rd_data = DW'({$urandom(), $urandom(), $urandom(), $urandom()});
    end

    // Port monitor: order, data, stall stability, occupancy, done pulses.
    int exp_rd = 0, exp_wr = 0, rd_seen = 0, wr_seen = 0, done_seen = 0, mon_err = 0, max_occ = 0;
    logic          stall_q = 1'b0;
    logic [AW-1:0] stall_addr = '0;
    logic [DW-1:0] stall_data = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_seen - wr_seen > max_occ) max_occ = rd_seen - wr_seen;
            if (rd_en) begin
                if (rd_addr != AW'(exp_rd)) mon_err++;
                exp_rd++;
                rd_seen++;
            end
            if (stall_q && !(wr_en && wr_addr == stall_addr && wr_data == stall_data)) mon_err++;
            if (wr_en && wr_ready) begin
                if (exp_wr >= WORDS) mon_err++;
                else if (wr_addr != AW'(exp_wr) || wr_data != relu(src[exp_wr])) mon_err++;
                exp_wr++;
                wr_seen++;
            end
            stall_q    = wr_en && !wr_ready;
            stall_addr = wr_addr;
            stall_data = wr_data;
            if (done) done_seen++;
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic clear_mon();
        exp_rd = 0; exp_wr = 0; rd_seen = 0; wr_seen = 0;
        done_seen = 0; mon_err = 0; max_occ = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic wait_done(input int max, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(posedge clk); #1;
            if (done) begin ok = 1'b1; break; end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic          ok;
    int            w0;

    initial begin
        src[0] = {16'hFF00, 16'h1234, 16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF};
        for (int w = 1; w < WORDS; w++)
            src[w] = DW'({$urandom(), $urandom(), $urandom(), $urandom()});

        rst_n = 1'b1; start = 1'b0; wr_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        `CHK("rst_rd_en",   rd_en,   1'b0)
        `CHK("rst_wr_en",   wr_en,   1'b0)
        `CHK("rst_busy",    busy,    1'b0)
        `CHK("rst_done",    done,    1'b0)
        `CHK("rst_rd_addr", rd_addr, 8'h00)
        `CHK("rst_wr_addr", wr_addr, 8'h00)
        `CHK("rst_wr_data", wr_data, 112'h0)
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Latency and ReLU lanes with wr_ready held high.
        clear_mon();
        pulse_start();
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            `CHK("lat_rd_en", rd_en, (k >= 1 && k <= 28))
            if (k <= 28) `CHK("lat_rd_addr", rd_addr, AW'(k - 1))
            `CHK("lat_wr_en", wr_en, (k >= 3 && k <= 30))
            if (k >= 3 && k <= 30) `CHK("lat_wr_addr", wr_addr, AW'(k - 3))
            if (k == 3)
                `CHK("relu_lanes", wr_data, {16'h0000, 16'h1234, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h7FFF})
            `CHK("lat_done", done, (k == 31))
            if (k == 1) `CHK("lat_busy_high", busy, 1'b1)
            if (k == 32) `CHK("lat_busy_low", busy, 1'b0)
        end
        `CHK("lat_mon_err",   mon_err,   0)
        `CHK("lat_reads",     rd_seen,   WORDS)
        `CHK("lat_writes",    wr_seen,   WORDS)
        `CHK("lat_done_once", done_seen, 1)

        // Five-cycle backpressure at word 10.
        clear_mon();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (wr_en && wr_addr == 8'd10) begin ok = 1'b1; break; end
        end
        `CHK("bp_reach_word10", ok, 1'b1)
        wr_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            `CHK("bp_wr_en_held",   wr_en,   1'b1)
            `CHK("bp_wr_addr_held", wr_addr, 8'd10)
            `CHK("bp_wr_data_held", wr_data, relu(src[10]))
            if (s >= 1) `CHK("bp_rd_stalled", rd_en, 1'b0)
            @(posedge clk); #1;
        end
        wr_ready = 1'b1;
        wait_done(200, ok);
        `CHK("bp_done",      ok,               1'b1)
        `CHK("bp_mon_err",   mon_err,          0)
        `CHK("bp_reads",     rd_seen,          WORDS)
        `CHK("bp_writes",    wr_seen,          WORDS)
        `CHK("bp_done_once", done_seen,        1)
        `CHK("bp_occupancy", (max_occ <= 2),   1'b1)

        // Random ready with a start pulse while busy.
        clear_mon();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (done) begin ok = 1'b1; break; end
            wr_ready = 1'($urandom_range(0, 1));
            start    = (i == 10);
            if (i == 10) `CHK("rnd_busy_at_pulse", busy, 1'b1)
        end
        start = 1'b0; wr_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        `CHK("rnd_done",      ok,             1'b1)
        `CHK("rnd_mon_err",   mon_err,        0)
        `CHK("rnd_reads",     rd_seen,        WORDS)
        `CHK("rnd_writes",    wr_seen,        WORDS)
        `CHK("rnd_done_once", done_seen,      1)
        `CHK("rnd_occupancy", (max_occ <= 2), 1'b1)
        `CHK("rnd_idle",      busy,           1'b0)

        // Asynchronous reset at word 15, then a fresh pass.
        clear_mon();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (rd_en && rd_addr == 8'd15) begin ok = 1'b1; break; end
        end
        `CHK("mid_reach_word15", ok, 1'b1)
        #3;
        rst_n = 1'b0;
        wr_ready = 1'($urandom_range(0, 1));
        start    = 1'($urandom_range(0, 1));
        #1;
        `CHK("mid_rst_rd_en",   rd_en,   1'b0)
        `CHK("mid_rst_wr_en",   wr_en,   1'b0)
        `CHK("mid_rst_busy",    busy,    1'b0)
        `CHK("mid_rst_done",    done,    1'b0)
        `CHK("mid_rst_rd_addr", rd_addr, 8'h00)
        `CHK("mid_rst_wr_addr", wr_addr, 8'h00)
        `CHK("mid_rst_wr_data", wr_data, 112'h0)
        w0 = wr_seen;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0; wr_ready = 1'b1; rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        `CHK("mid_no_writes", wr_seen, w0)
        `CHK("mid_idle",      busy,    1'b0)
        clear_mon();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rd_en) begin ok = 1'b1; break; end
        end
        `CHK("mid_restart_rd", ok,      1'b1)
        `CHK("mid_first_addr", rd_addr, 8'h00)
        wait_done(200, ok);
        `CHK("mid_done",      ok,        1'b1)
        `CHK("mid_mon_err",   mon_err,   0)
        `CHK("mid_reads",     rd_seen,   WORDS)
        `CHK("mid_writes",    wr_seen,   WORDS)
        `CHK("mid_done_once", done_seen, 1)

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
